// File: rtl/booth_mul_issue_ctrl_pkg.sv
// Shared widths, defaults and helpers for the booth multiplier issue front-end.
// BOOTH_MUL_LAT is the single place the multiplier pipeline depth is set.
package booth_mul_issue_ctrl_pkg;

  localparam int unsigned BOOTH_MUL_LAT  = 5;
  localparam int unsigned FIFO_DEPTH_DEF = 8;
  localparam int unsigned TAG_W_DEF      = 4;
  localparam int unsigned DATA_W         = 32;
  localparam int unsigned PROD_W         = 64;
  localparam int unsigned PERF_W         = 32;

  // Saturating increment for event counters
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + PERF_W'(1) : v;
  endfunction

endpackage

// File: rtl/booth_mul_issue_ctrl_if.sv
// Request/result/multiplier bus of booth_mul_issue_ctrl.
// Perf counter outputs exist only when BOOTH_MUL_PERF_EN is defined.
interface booth_mul_issue_ctrl_if
  import booth_mul_issue_ctrl_pkg::*;
#(
  parameter int unsigned TAG_W = TAG_W_DEF
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              in_hi;
  logic [TAG_W-1:0]  in_tag;
  logic [DATA_W-1:0] mul_a;
  logic [DATA_W-1:0] mul_b;
  logic [PROD_W-1:0] mul_result;
  logic              out_valid;
  logic              out_ready;
  logic [PROD_W-1:0] out_prod;
  logic [DATA_W-1:0] out_word;
  logic [TAG_W-1:0]  out_tag;
`ifdef BOOTH_MUL_PERF_EN
  logic [PERF_W-1:0] perf_issue;
  logic [PERF_W-1:0] perf_stall;
  logic [PERF_W-1:0] perf_bp;

  modport slave (
    input  flush, in_valid, in_a, in_b, in_hi, in_tag, mul_result, out_ready,
    output in_ready, mul_a, mul_b, out_valid, out_prod, out_word, out_tag,
           perf_issue, perf_stall, perf_bp
  );
  modport master (
    output flush, in_valid, in_a, in_b, in_hi, in_tag, mul_result, out_ready,
    input  in_ready, mul_a, mul_b, out_valid, out_prod, out_word, out_tag,
           perf_issue, perf_stall, perf_bp
  );
`else
  modport slave (
    input  flush, in_valid, in_a, in_b, in_hi, in_tag, mul_result, out_ready,
    output in_ready, mul_a, mul_b, out_valid, out_prod, out_word, out_tag
  );
  modport master (
    output flush, in_valid, in_a, in_b, in_hi, in_tag, mul_result, out_ready,
    input  in_ready, mul_a, mul_b, out_valid, out_prod, out_word, out_tag
  );
`endif
endinterface

// File: rtl/booth_mul_issue_ctrl_res_fifo.sv
// booth_res_fifo: synchronous FIFO with a registered head entry and pointer-based
// full/empty flags (no occupancy counter). DEPTH must be a power of two.
module booth_res_fifo #(
  parameter int unsigned WIDTH = 69,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic [WIDTH-1:0] rdata,
  output logic             empty
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             head_vld;
  logic [WIDTH-1:0] head;
  logic             mem_empty, mem_full, pop, load, bypass, mem_wr, mem_rd;

  assign mem_empty = (wr_ptr == rd_ptr);
  assign mem_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // Head refills from storage first, otherwise straight from the write port
  assign pop       = head_vld && rd;
  assign load      = !head_vld || pop;
  assign bypass    = load && mem_empty && wr;
  assign mem_wr    = wr && !bypass;
  assign mem_rd    = load && !mem_empty;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      head_vld <= 1'b0;
      head     <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      head_vld <= 1'b0;
      head     <= '0;
    end else begin
      if (mem_wr) wr_ptr <= wr_ptr + PW'(1);
      if (mem_rd) rd_ptr <= rd_ptr + PW'(1);
      if (load) begin
        head_vld <= mem_rd || bypass;
        if (mem_rd)      head <= mem[rd_ptr[AW-1:0]];
        else if (bypass) head <= wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_wr && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = head;
  assign empty = !head_vld;

  // Upstream credits make a write into a full store impossible
  mem_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
    !(mem_wr && mem_full && !mem_rd && !flush));

endmodule

// File: rtl/booth_mul_issue_ctrl.sv
// Valid/ready front-end for the fixed-latency booth_multiplier: operand registers,
// in-flight tracking pipeline, credit counter and result FIFO. Optional BOOTH_MUL_PERF_EN.
module booth_mul_issue_ctrl
  import booth_mul_issue_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT    = BOOTH_MUL_LAT,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned TAG_W      = TAG_W_DEF
) (
  input logic                  clk,
  input logic                  rstn,
  booth_mul_issue_ctrl_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned ENT_W = PROD_W + 1 + TAG_W;

  logic              accept, pop, ready_q, out_hi;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic [DATA_W-1:0] mul_a_q, mul_b_q;
  logic [MUL_LAT:0]  vld_q, hi_q;
  logic [TAG_W-1:0]  tag_q [MUL_LAT+1];
  logic [ENT_W-1:0]  fifo_rdata;
  logic              fifo_empty;

  assign bus.in_ready = ready_q && !bus.flush;
  assign accept       = bus.in_valid && bus.in_ready;
  assign pop          = bus.out_valid && bus.out_ready && !bus.flush;

  // Credits cover both in-flight and buffered results
  always_comb begin
    cnt_nxt = cnt_q;
    if (bus.flush)           cnt_nxt = '0;
    else if (accept && !pop) cnt_nxt = cnt_q + CNT_W'(1);
    else if (!accept && pop) cnt_nxt = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q   <= '0;
      ready_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_nxt;
      ready_q <= (cnt_nxt < CNT_W'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mul_a_q <= '0;
      mul_b_q <= '0;
    end else if (accept) begin
      mul_a_q <= bus.in_a;
      mul_b_q <= bus.in_b;
    end
  end

  assign bus.mul_a = mul_a_q;
  assign bus.mul_b = mul_b_q;

  // Stage 0 aligns with mul_a/mul_b; stage MUL_LAT aligns with mul_result
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q <= '0;
      hi_q  <= '0;
      for (int i = 0; i <= int'(MUL_LAT); i++) tag_q[i] <= '0;
    end else begin
      vld_q    <= bus.flush ? '0 : {vld_q[MUL_LAT-1:0], accept};
      hi_q     <= {hi_q[MUL_LAT-1:0], bus.in_hi};
      tag_q[0] <= bus.in_tag;
      for (int i = 1; i <= int'(MUL_LAT); i++) tag_q[i] <= tag_q[i-1];
    end
  end

  booth_res_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_res_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .flush (bus.flush),
    .wr    (vld_q[MUL_LAT]),
    .wdata ({bus.mul_result, hi_q[MUL_LAT], tag_q[MUL_LAT]}),
    .rd    (bus.out_ready),
    .rdata (fifo_rdata),
    .empty (fifo_empty)
  );

  assign {bus.out_prod, out_hi, bus.out_tag} = fifo_rdata;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_word  = out_hi ? bus.out_prod[PROD_W-1:DATA_W] : bus.out_prod[DATA_W-1:0];

`ifdef BOOTH_MUL_PERF_EN
  logic [PERF_W-1:0] perf_issue_q, perf_stall_q, perf_bp_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_issue_q <= '0;
      perf_stall_q <= '0;
      perf_bp_q    <= '0;
    end else if (bus.flush) begin
      perf_issue_q <= '0;
      perf_stall_q <= '0;
      perf_bp_q    <= '0;
    end else begin
      perf_issue_q <= sat_inc(perf_issue_q, accept);
      perf_stall_q <= sat_inc(perf_stall_q, bus.in_valid && !bus.in_ready);
      perf_bp_q    <= sat_inc(perf_bp_q, bus.out_valid && !bus.out_ready);
    end
  end

  assign bus.perf_issue = perf_issue_q;
  assign bus.perf_stall = perf_stall_q;
  assign bus.perf_bp    = perf_bp_q;
`endif

endmodule

// File: tb/tb_booth_mul_issue_ctrl.sv
// Directed bench for booth_mul_issue_ctrl with a 5-deep multiplier model on mul_a/mul_b.
// Honours BOOTH_MUL_PERF_EN for the perf counter reset checks.
module tb_booth_mul_issue_ctrl;
  import booth_mul_issue_ctrl_pkg::*;

  typedef struct packed {
    logic [63:0] prod;
    logic [31:0] word;
    logic [3:0]  tag;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_acc = 0;
  int   n_pop = 0;
  int   n_stall = 0;
  logic popped, rdy;
  exp_t exp_q[$];
  logic [63:0] mp [5];

  always #5 clk = ~clk;

  booth_mul_issue_ctrl_if #(.TAG_W(4)) bus ();

  booth_mul_issue_ctrl #(
    .MUL_LAT    (5),
    .FIFO_DEPTH (8),
    .TAG_W      (4)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // Fixed-latency multiplier stand-in: result valid 5 cycles after mul_a/mul_b
  always @(posedge clk) begin
    mp[0] <= 64'($signed({{32{bus.mul_a[31]}}, bus.mul_a}) * $signed({{32{bus.mul_b[31]}}, bus.mul_b}));
    for (int i = 1; i < 5; i++) mp[i] <= mp[i-1];
  end
  assign bus.mul_result = mp[4];

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic hi, input logic [3:0] tag);
    logic signed [63:0] sa, sb;
    exp_t e;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    e.prod = 64'(sa * sb);
    e.word = hi ? e.prod[63:32] : e.prod[31:0];
    e.tag  = tag;
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Sample handshakes at negedge, then advance to just after the next posedge
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    popped = 1'b0;
    rdy    = bus.in_ready;
    if (bus.in_valid && bus.in_ready) begin
      exp_q.push_back(model(bus.in_a, bus.in_b, bus.in_hi, bus.in_tag));
      n_acc++;
    end
    if (bus.in_valid && !bus.in_ready) n_stall++;
    if (bus.out_valid && bus.out_ready && !bus.flush) begin
      popped = 1'b1;
      n_pop++;
      if (exp_q.size() == 0) begin
        check("unexpected_pop", 64'(bus.out_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("pop_prod", bus.out_prod, e.prod);
        check("pop_word", 64'(bus.out_word), 64'(e.word));
        check("pop_tag", 64'(bus.out_tag), 64'(e.tag));
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic hi, input logic [3:0] tag);
    bus.in_valid = v;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_hi    = hi;
    bus.in_tag   = tag;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      cycle();
      n++;
    end
    check(tag, 64'(bus.out_valid), 64'd1);
  endtask

  task automatic check_perf_zero();
`ifdef BOOTH_MUL_PERF_EN
    check("perf_issue_zero", 64'(bus.perf_issue), 64'd0);
    check("perf_stall_zero", 64'(bus.perf_stall), 64'd0);
    check("perf_bp_zero", 64'(bus.perf_bp), 64'd0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int first, last, base, pop_c, rdy_c;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_prod", bus.out_prod, 64'd0);
    check("rst_out_word", 64'(bus.out_word), 64'd0);
    check("rst_out_tag", 64'(bus.out_tag), 64'd0);
    check("rst_mul_a", 64'(bus.mul_a), 64'd0);
    check_perf_zero();

    // 1: single op, latency to out_valid
    bus.out_ready = 1'b1;
    drive(1'b1, 32'd3, 32'd5, 1'b0, 4'd2);
    cycle();
    bus.in_valid = 1'b0;
    for (int i = 1; i < 7; i++) begin
      check("t1_early_valid", 64'(bus.out_valid), 64'd0);
      cycle();
    end
    check("t1_valid_c7", 64'(bus.out_valid), 64'd1);
    check("t1_prod", bus.out_prod, 64'd15);
    check("t1_word", 64'(bus.out_word), 64'd15);
    check("t1_tag", 64'(bus.out_tag), 64'd2);
    cycle();

    // 2: signed corner cases and high-half select
    drive(1'b1, 32'hFFFF_FFFF, 32'd2, 1'b1, 4'd5);
    cycle();
    drive(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 4'd6);
    cycle();
    bus.in_valid = 1'b0;
    wait_valid("t2_timeout_a");
    check("t2_prod_a", bus.out_prod, 64'hFFFF_FFFF_FFFF_FFFE);
    check("t2_word_a", 64'(bus.out_word), 64'h0000_0000_FFFF_FFFF);
    check("t2_tag_a", 64'(bus.out_tag), 64'd5);
    cycle();
    check("t2_prod_b", bus.out_prod, 64'h4000_0000_0000_0000);
    check("t2_word_b", 64'(bus.out_word), 64'd0);
    check("t2_tag_b", 64'(bus.out_tag), 64'd6);
    check("t2_mul_a_hold", 64'(bus.mul_a), 64'h8000_0000);
    cycle();

    // 3: 100 back-to-back random ops with out_ready held
    n_stall = 0;
    base = n_pop;
    first = -1;
    last = -1;
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      cycle();
      if (popped) begin
        if (first < 0) first = cyc - 1;
        last = cyc - 1;
      end
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 20 && n_pop < base + 100; i++) begin
      cycle();
      if (popped) begin
        if (first < 0) first = cyc - 1;
        last = cyc - 1;
      end
    end
    check("t3_no_stall", 64'(n_stall), 64'd0);
    check("t3_pop_count", 64'(n_pop - base), 64'd100);
    check("t3_one_per_cycle", 64'(last - first), 64'd99);

    // 4: credit limit under full backpressure
    bus.out_ready = 1'b0;
    base = n_acc;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'(i * 3 + 1), ~32'(i), 1'(i), 4'(i));
      cycle();
    end
    check("t4_accepts", 64'(n_acc - base), 64'd8);
    check("t4_in_ready_low", 64'(rdy), 64'd0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    base = n_pop;
    pop_c = -1;
    rdy_c = -1;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (popped && pop_c < 0) pop_c = cyc - 1;
      if (rdy && pop_c >= 0 && rdy_c < 0) rdy_c = cyc - 1;
    end
    check("t4_drain_count", 64'(n_pop - base), 64'd8);
    check("t4_ready_after_pop", 64'(rdy_c - pop_c), 64'd1);

    // 5: flush with 3 in flight and 2 buffered
    bus.out_ready = 1'b0;
    drive(1'b1, 32'd11, 32'd2, 1'b0, 4'd1);
    cycle();
    drive(1'b1, 32'd12, 32'd2, 1'b0, 4'd2);
    cycle();
    bus.in_valid = 1'b0;
    repeat (3) cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(20 + i), 32'd3, 1'b0, 4'(3 + i));
      cycle();
    end
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check("t5_flush_in_ready", 64'(bus.in_ready), 64'd0);
    cycle();
    bus.flush = 1'b0;
    exp_q.delete();
    #1;
    check("t5_out_valid_clr", 64'(bus.out_valid), 64'd0);
    check("t5_in_ready_set", 64'(bus.in_ready), 64'd1);
    check_perf_zero();
    drive(1'b1, 32'd7, 32'd6, 1'b0, 4'd9);
    cycle();
    bus.in_valid = 1'b0;
    wait_valid("t5_timeout");
    check("t5_prod_42", bus.out_prod, 64'd42);
    check("t5_tag", 64'(bus.out_tag), 64'd9);
    repeat (12) cycle();

    // 6: asynchronous reset mid-stream
    bus.out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 32'(i + 5), 32'(i + 9), 1'b0, 4'(i));
      cycle();
    end
    #2 rstn = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("t6_out_valid_rst", 64'(bus.out_valid), 64'd0);
    check("t6_in_ready_rst", 64'(bus.in_ready), 64'd1);
    check("t6_mul_a_rst", 64'(bus.mul_a), 64'd0);
    check_perf_zero();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    bus.out_ready = 1'b1;
    base = n_pop;
    repeat (15) cycle();
    check("t6_no_stale", 64'(n_pop - base), 64'd0);
    check("t6_out_valid_idle", 64'(bus.out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
